// File: rtl/jtag_tap_ctrl.sv
// IEEE 1149.1 TAP controller sampled in the system clk domain.
// It runs the 16-state TAP FSM, holds the IR and produces one-clk DR strobes for the DTM.
module jtag_tap_ctrl #(
    parameter int                  IR_WIDTH    = 5,
    parameter logic [IR_WIDTH-1:0] IR_RESET    = IR_WIDTH'(5'h01),
    parameter int                  SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                tck,
    input  logic                tms,
    input  logic                tdi,
    output logic                tdo,
    output logic                tdo_en,
    input  logic                dr_tdo,
    output logic                tdi_s,
    output logic                capture_dr,
    output logic                shift_dr,
    output logic                update_dr,
    output logic [IR_WIDTH-1:0] ir_out,
    output logic [3:0]          tap_state
);

    typedef enum logic [3:0] {
        TLR     = 4'd0,
        RTI     = 4'd1,
        SELDR   = 4'd2,
        CAPDR   = 4'd3,
        SHDR    = 4'd4,
        EX1DR   = 4'd5,
        PAUSEDR = 4'd6,
        EX2DR   = 4'd7,
        UPDDR   = 4'd8,
        SELIR   = 4'd9,
        CAPIR   = 4'd10,
        SHIR    = 4'd11,
        EX1IR   = 4'd12,
        PAUSEIR = 4'd13,
        EX2IR   = 4'd14,
        UPDIR   = 4'd15
    } tap_state_e;

    localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(2'b01);

    logic [SYNC_STAGES-1:0] tck_sync;
    logic [SYNC_STAGES-1:0] tms_sync;
    logic [SYNC_STAGES-1:0] tdi_sync;
    logic                   tck_prev;
    logic                   tck_s;
    logic                   tms_s;
    logic                   tck_rise;
    logic                   tck_fall;

    tap_state_e             state;
    tap_state_e             next_state;
    logic [IR_WIDTH-1:0]    ir_shift;

    // All three pins share the same depth so tms/tdi stay aligned with the tck edge detect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tck_sync <= '0;
            tms_sync <= '0;
            tdi_sync <= '0;
            tck_prev <= 1'b0;
        end else begin
            tck_sync <= {tck_sync[SYNC_STAGES-2:0], tck};
            tms_sync <= {tms_sync[SYNC_STAGES-2:0], tms};
            tdi_sync <= {tdi_sync[SYNC_STAGES-2:0], tdi};
            tck_prev <= tck_s;
        end
    end

    assign tck_s    = tck_sync[SYNC_STAGES-1];
    assign tms_s    = tms_sync[SYNC_STAGES-1];
    assign tdi_s    = tdi_sync[SYNC_STAGES-1];
    assign tck_rise = tck_s & ~tck_prev;
    assign tck_fall = ~tck_s & tck_prev;

    always_comb begin
        next_state = state;
        unique case (state)
            TLR:     next_state = tms_s ? TLR     : RTI;
            RTI:     next_state = tms_s ? SELDR   : RTI;
            SELDR:   next_state = tms_s ? SELIR   : CAPDR;
            CAPDR:   next_state = tms_s ? EX1DR   : SHDR;
            SHDR:    next_state = tms_s ? EX1DR   : SHDR;
            EX1DR:   next_state = tms_s ? UPDDR   : PAUSEDR;
            PAUSEDR: next_state = tms_s ? EX2DR   : PAUSEDR;
            EX2DR:   next_state = tms_s ? UPDDR   : SHDR;
            UPDDR:   next_state = tms_s ? SELDR   : RTI;
            SELIR:   next_state = tms_s ? TLR     : CAPIR;
            CAPIR:   next_state = tms_s ? EX1IR   : SHIR;
            SHIR:    next_state = tms_s ? EX1IR   : SHIR;
            EX1IR:   next_state = tms_s ? UPDIR   : PAUSEIR;
            PAUSEIR: next_state = tms_s ? EX2IR   : PAUSEIR;
            EX2IR:   next_state = tms_s ? UPDIR   : SHIR;
            UPDIR:   next_state = tms_s ? SELDR   : RTI;
            default: next_state = TLR;
        endcase
    end

    // State, IR and TDO move on TCK edges; tck_rise and tck_fall never coincide
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= TLR;
            ir_shift <= IR_RESET;
            ir_out   <= IR_RESET;
            tdo      <= 1'b0;
            tdo_en   <= 1'b0;
        end else begin
            if (tck_rise) begin
                state <= next_state;
                if (next_state == TLR) begin
                    ir_shift <= IR_RESET;
                    ir_out   <= IR_RESET;
                end else if (state == CAPIR) begin
                    ir_shift <= IR_CAPTURE;
                end else if (state == SHIR) begin
                    ir_shift <= {tdi_s, ir_shift[IR_WIDTH-1:1]};
                end
            end
            if (tck_fall) begin
                if (state == UPDIR) begin
                    ir_out <= ir_shift;
                end
                if (state == SHDR) begin
                    tdo <= dr_tdo;
                end else if (state == SHIR) begin
                    tdo <= ir_shift[0];
                end
                tdo_en <= (state == SHDR) || (state == SHIR);
            end
        end
    end

    assign capture_dr = tck_rise && (state == CAPDR);
    assign shift_dr   = tck_rise && (state == SHDR);
    assign update_dr  = tck_fall && (state == UPDDR);
    assign tap_state  = state;

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Randomized bench for jtag_tap_ctrl: a TCK-level table model of the TAP is compared
// against the DUT at the end of every TCK half period, plus hand-computed scan results.
module tb_jtag_tap_ctrl;

    localparam int HALF = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tck = 1'b0;
    logic       tms = 1'b1;
    logic       tdi = 1'b0;
    logic       dr_tdo = 1'b0;
    logic       tdo;
    logic       tdo_en;
    logic       tdi_s;
    logic       capture_dr;
    logic       shift_dr;
    logic       update_dr;
    logic [4:0] ir_out;
    logic [3:0] tap_state;

    jtag_tap_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tck        (tck),
        .tms        (tms),
        .tdi        (tdi),
        .tdo        (tdo),
        .tdo_en     (tdo_en),
        .dr_tdo     (dr_tdo),
        .tdi_s      (tdi_s),
        .capture_dr (capture_dr),
        .shift_dr   (shift_dr),
        .update_dr  (update_dr),
        .ir_out     (ir_out),
        .tap_state  (tap_state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int cap_cnt = 0;
    int sh_cnt  = 0;
    int upd_cnt = 0;
    logic last_tdi_s = 1'b0;

    // Standard 1149.1 next-state table indexed by state number
    int nx0 [16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
    int nx1 [16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};

    int          m_st = 0;
    logic [4:0]  m_ir = 5'h01;
    logic [4:0]  m_ir_shift = 5'h01;
    logic        m_tdo = 1'b0;
    logic        m_tdo_en = 1'b0;
    logic [40:0] dr_reg = '0;
    logic [4:0]  ir_at_rise = '0;

    always @(negedge clk) begin
        if (capture_dr) cap_cnt++;
        if (shift_dr) begin
            sh_cnt++;
            last_tdi_s = tdi_s;
        end
        if (update_dr) upd_cnt++;
    end

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic compare_model(input string ph, input logic e_cap, input logic e_sh, input logic e_upd,
                                 input logic d, input int c0, input int s0, input int u0);
        check_output({ph, " tap_state"}, 64'(tap_state), 64'(m_st));
        check_output({ph, " ir_out"}, 64'(ir_out), 64'(m_ir));
        check_output({ph, " tdo"}, 64'(tdo), 64'(m_tdo));
        check_output({ph, " tdo_en"}, 64'(tdo_en), 64'(m_tdo_en));
        check_output({ph, " capture_dr count"}, 64'(cap_cnt - c0), 64'(e_cap));
        check_output({ph, " shift_dr count"}, 64'(sh_cnt - s0), 64'(e_sh));
        check_output({ph, " update_dr count"}, 64'(upd_cnt - u0), 64'(e_upd));
        if (e_sh) check_output({ph, " tdi_s at shift"}, 64'(last_tdi_s), 64'(d));
    endtask

    // One full TCK period: tms/tdi set while TCK is low, then rise and fall
    task automatic apply_stimulus(input logic m, input logic d);
        int c0, s0, u0;
        logic e_cap, e_sh, e_upd;
        tms = m;
        tdi = d;
        repeat (2) @(negedge clk);
        c0 = cap_cnt; s0 = sh_cnt; u0 = upd_cnt;
        e_cap = (m_st == 3);
        e_sh  = (m_st == 4);
        if (e_cap) dr_reg = 41'({$urandom, $urandom});
        if (e_sh) dr_reg = {d, dr_reg[40:1]};
        if (m_st == 10) m_ir_shift = 5'h01;
        else if (m_st == 11) m_ir_shift = {d, m_ir_shift[4:1]};
        m_st = m ? nx1[m_st] : nx0[m_st];
        if (m_st == 0) begin
            m_ir_shift = 5'h01;
            m_ir = 5'h01;
        end
        tck = 1'b1;
        dr_tdo = dr_reg[0];
        repeat (HALF) @(negedge clk);
        compare_model("rise", e_cap, e_sh, 1'b0, d, c0, s0, u0);
        ir_at_rise = ir_out;

        c0 = cap_cnt; s0 = sh_cnt; u0 = upd_cnt;
        e_upd = (m_st == 8);
        if (m_st == 15) m_ir = m_ir_shift;
        if (m_st == 4) m_tdo = dr_tdo;
        else if (m_st == 11) m_tdo = m_ir_shift[0];
        m_tdo_en = (m_st == 4) || (m_st == 11);
        tck = 1'b0;
        repeat (HALF) @(negedge clk);
        compare_model("fall", 1'b0, 1'b0, e_upd, d, c0, s0, u0);
    endtask

    task automatic mid_scan_reset();
        int u0;
        u0 = upd_cnt;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_output("async reset tap_state", 64'(tap_state), 64'd0);
        check_output("async reset ir_out", 64'(ir_out), 64'h01);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (HALF) @(negedge clk);
        m_st = 0; m_ir = 5'h01; m_ir_shift = 5'h01; m_tdo = 1'b0; m_tdo_en = 1'b0;
        check_output("post reset tap_state", 64'(tap_state), 64'd0);
        check_output("post reset tdo_en", 64'(tdo_en), 64'd0);
        check_output("post reset ir_out", 64'(ir_out), 64'h01);
        check_output("post reset update_dr", 64'(upd_cnt - u0), 64'd0);
    endtask

    initial begin
        logic [4:0] ir_val;
        logic [4:0] cap_vec;
        int c0, s0, u0;

        repeat (3) @(negedge clk);
        check_output("reset tap_state", 64'(tap_state), 64'd0);
        check_output("reset tdo", 64'(tdo), 64'd0);
        check_output("reset tdo_en", 64'(tdo_en), 64'd0);
        check_output("reset ir_out", 64'(ir_out), 64'h01);
        check_output("reset strobes", 64'({capture_dr, shift_dr, update_dr}), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 5; i++) apply_stimulus(1'b1, 1'b0);
        check_output("tlr after tms x5", 64'(tap_state), 64'd0);
        apply_stimulus(1'b0, 1'b0);
        check_output("rti literal", 64'(tap_state), 64'd1);
        check_output("rti ir_out literal", 64'(ir_out), 64'h01);

        // IR scan of 0x11; captured 0b00001 must come out on tdo LSB first
        ir_val = 5'h11;
        apply_stimulus(1'b1, 1'b0);
        apply_stimulus(1'b1, 1'b0);
        apply_stimulus(1'b0, 1'b0);
        apply_stimulus(1'b0, 1'b0);
        cap_vec[0] = tdo;
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(i == 4, ir_val[i]);
            if (i < 4) cap_vec[i+1] = tdo;
        end
        apply_stimulus(1'b1, 1'b0);
        check_output("ir captured tdo literal", 64'(cap_vec), 64'h01);
        check_output("ir_out before updir fall", 64'(ir_at_rise), 64'h01);
        check_output("ir_out after updir fall", 64'(ir_out), 64'h11);
        apply_stimulus(1'b0, 1'b0);

        c0 = cap_cnt; s0 = sh_cnt; u0 = upd_cnt;
        apply_stimulus(1'b1, 1'b0);
        apply_stimulus(1'b0, 1'b0);
        apply_stimulus(1'b0, 1'b0);
        for (int i = 0; i < 41; i++) apply_stimulus(i == 40, 1'($urandom));
        apply_stimulus(1'b1, 1'b0);
        apply_stimulus(1'b0, 1'b0);
        check_output("dr41 capture total", 64'(cap_cnt - c0), 64'd1);
        check_output("dr41 shift total", 64'(sh_cnt - s0), 64'd41);
        check_output("dr41 update total", 64'(upd_cnt - u0), 64'd1);

        // Pause in the middle of a DR scan: no second capture
        c0 = cap_cnt; s0 = sh_cnt; u0 = upd_cnt;
        apply_stimulus(1'b1, 1'b0);
        apply_stimulus(1'b0, 1'b0);
        apply_stimulus(1'b0, 1'b0);
        for (int i = 0; i < 10; i++) apply_stimulus(i == 9, 1'($urandom));
        for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 1'b0);
        apply_stimulus(1'b1, 1'b0);
        apply_stimulus(1'b0, 1'b0);
        for (int i = 0; i < 31; i++) apply_stimulus(i == 30, 1'($urandom));
        apply_stimulus(1'b1, 1'b0);
        apply_stimulus(1'b0, 1'b0);
        check_output("pause capture total", 64'(cap_cnt - c0), 64'd1);
        check_output("pause shift total", 64'(sh_cnt - s0), 64'd41);

        u0 = upd_cnt;
        apply_stimulus(1'b1, 1'b0);
        apply_stimulus(1'b1, 1'b0);
        apply_stimulus(1'b0, 1'b0);
        apply_stimulus(1'b0, 1'b0);
        apply_stimulus(1'b0, 1'b1);
        apply_stimulus(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) apply_stimulus(1'b1, 1'b0);
        check_output("shir escape tap_state", 64'(tap_state), 64'd0);
        check_output("shir escape ir_out", 64'(ir_out), 64'h01);
        check_output("shir escape update_dr", 64'(upd_cnt - u0), 64'd0);

        c0 = cap_cnt; s0 = sh_cnt; u0 = upd_cnt;
        for (int i = 0; i < 4; i++) apply_stimulus(1'b1, 1'($urandom));
        check_output("tlr hold strobes", 64'((cap_cnt - c0) + (sh_cnt - s0) + (upd_cnt - u0)), 64'd0);
        check_output("tlr hold tap_state", 64'(tap_state), 64'd0);

        apply_stimulus(1'b0, 1'b0);
        apply_stimulus(1'b1, 1'b0);
        apply_stimulus(1'b0, 1'b0);
        apply_stimulus(1'b0, 1'b0);
        apply_stimulus(1'b0, 1'b1);
        apply_stimulus(1'b1, 1'b0);
        apply_stimulus(1'b0, 1'b0);
        check_output("pausedr literal", 64'(tap_state), 64'd6);
        for (int i = 0; i < 5; i++) apply_stimulus(1'b1, 1'b0);
        check_output("pausedr escape tap_state", 64'(tap_state), 64'd0);
        check_output("pausedr escape ir_out", 64'(ir_out), 64'h01);

        apply_stimulus(1'b0, 1'b0);
        apply_stimulus(1'b1, 1'b0);
        apply_stimulus(1'b0, 1'b0);
        apply_stimulus(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) apply_stimulus(1'b0, 1'($urandom));
        mid_scan_reset();
        for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 1'b0);

        // Random walk through the FSM, biased towards tms=0 so scans actually happen
        for (int i = 0; i < 300; i++) begin
            apply_stimulus($urandom_range(0, 3) == 0, 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/jtag_tap_ctrl.md
Name: jtag_tap_ctrl

Overview:
- IEEE 1149.1 TAP controller that oversamples external TCK/TMS/TDI in the system clk domain.
- Runs the 16-state TAP FSM and holds the instruction register.
- Drives single-clk-cycle capture/shift/update DR strobes, ir_out and a synchronized TDI to the downstream DTM, and muxes the DTM's serial output onto TDO.
- Sits between the chip JTAG pins and the DTM.

Parameters:
- IR_WIDTH, 5, instruction register width.
- IR_RESET, 5'h01, ir_out value after reset and in Test-Logic-Reset (IDCODE).
- SYNC_STAGES, 2, synchronizer flops on tck/tms/tdi (legal range 2..4).

Ports:
- clk  input  1  system clock; must be at least 4x TCK frequency.
- rst_n  input  1  reset, asynchronous, active-low.
- tck  input  1  JTAG test clock (asynchronous to clk).
- tms  input  1  JTAG mode select.
- tdi  input  1  JTAG serial data in.
- tdo  output  1  JTAG serial data out.
- tdo_en  output  1  TDO output enable; high only in Shift-DR/Shift-IR.
- dr_tdo  input  1  serial output of the selected DR from the DTM.
- tdi_s  output  1  synchronized TDI to the DTM.
- capture_dr  output  1  one-clk strobe.
- shift_dr  output  1  one-clk strobe.
- update_dr  output  1  one-clk strobe.
- ir_out  output  IR_WIDTH  current instruction.
- tap_state  output  4  current FSM state encoding, for debug.

Behaviour:
- Synchronization
  - tck, tms and tdi each pass through SYNC_STAGES flops.
  - A further flop on synchronized tck gives edge detects: tck_rise = s & ~prev, tck_fall = ~s & prev.
  - Each edge detect is high exactly one clk cycle per TCK edge.
- State encoding
  - TLR=0, RTI=1, SELDR=2, CAPDR=3, SHDR=4, EX1DR=5, PAUSEDR=6, EX2DR=7, UPDDR=8, SELIR=9, CAPIR=10, SHIR=11, EX1IR=12, PAUSEIR=13, EX2IR=14, UPDIR=15.
- FSM
  - Advances only on tck_rise, using synchronized tms, per the standard 1149.1 transition table.
  - Reset state is TLR.
- DR strobes (combinational from the registered state and tck_rise/tck_fall, each one clk wide)
  - capture_dr = tck_rise & state==CAPDR.
  - shift_dr = tck_rise & state==SHDR.
  - update_dr = tck_fall & state==UPDDR.
  - Exactly one capture_dr per pass through CAPDR.
  - Exactly one shift_dr per TCK rising edge spent in SHDR, including the edge that exits with tms=1.
  - tdi_s is stable while shift_dr is high.
- Instruction register
  - ir_shift[IR_WIDTH-1:0].
  - On tck_rise in CAPIR: ir_shift loads {0..,2'b01}.
  - On tck_rise in SHIR: ir_shift = {tdi_s, ir_shift[IR_WIDTH-1:1]}.
  - On tck_fall in UPDIR: ir_out <= ir_shift.
  - On entering TLR, and at reset: ir_out <= IR_RESET and ir_shift <= IR_RESET.
- TDO
  - Registered, updated on tck_fall.
  - In SHDR: tdo <= dr_tdo. In SHIR: tdo <= ir_shift[0]. Otherwise tdo holds its value.
  - tdo_en is registered on tck_fall: 1 when state is SHDR or SHIR, else 0.
- Reset values
  - tdo=0, tdo_en=0, all strobes=0, ir_out=IR_RESET, tap_state=TLR, synchronizer flops=0.
- Boundary conditions
  - Five consecutive TCK rising edges with tms=1 reach TLR from any state.
  - tms=1 held while in TLR stays in TLR with no strobes.
  - rst_n asserted mid-shift: immediate asynchronous return to TLR; ir_out=IR_RESET; no update_dr is emitted for the aborted scan.
  - Pause states shift nothing; re-entering SHDR via EX2DR resumes shift_dr pulses without a new capture_dr.
  - TCK glitches shorter than one clk period may be missed; this is legal given the 4x ratio requirement.

Test Plan:
- Reset, then TMS=1 x5, TMS=0 -> tap_state 0 then 1; ir_out=0x01; tdo_en=0; no strobes.
- IR scan: TMS 1,1,0,0 then shift 0x11 LSB-first (last bit with tms=1), then 1,0 -> tdo emits captured 0b00001 LSB-first; ir_out becomes 0x11 on the UPDIR falling edge, not before.
- DR scan of 41 bits with dr_tdo driven by a shift-register model -> exactly 1 capture_dr, 41 shift_dr and 1 update_dr pulses; tdo sequence equals the model's output shifted one TCK falling edge; tdi_s bits match the driven tdi.
- DR scan with Pause-DR: shift 10 bits, pause for 3 TCKs, resume and shift 31 more -> 41 shift_dr pulses and a single capture_dr.
- From SHIR and from PAUSEDR, drive TMS=1 x5 -> state TLR; ir_out=0x01; no update_dr emitted.
- Assert rst_n low mid-DR-shift for 2 clk, then release -> tap_state=0; tdo_en=0; ir_out=0x01; no update_dr pulse.
